// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator: 1-bit PDM in (sampled on rising ock), 32-bit PCM out at ock/2**LOG2D.
// Integrators run on synchronised ock edges; a 3-stage comb pipeline follows each decimation tick.
module pdm_cic_decimator #(
  parameter int unsigned LOG2D = 6,
  parameter int unsigned ORDER = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        signed_data_i,
  input  logic        ock_i,
  input  logic        sdi_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o
);

  localparam int unsigned AccW  = 3 * LOG2D + 1;
  localparam int unsigned Shift = 32 - 3 * LOG2D;

  if (ORDER != 3) begin : gen_order_err
    $error("pdm_cic_decimator: ORDER must be 3");
  end
  if (LOG2D < 3 || LOG2D > 10) begin : gen_log2d_err
    $error("pdm_cic_decimator: LOG2D must be in 3..10");
  end

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  // Input capture: ock through 2 sync flops plus one for edge detect; sdi delayed to match.
  logic [2:0] ock_q;
  logic [1:0] sdi_q;
  logic       bit_en;
  logic       sdi_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ock_q <= '0;
      sdi_q <= '0;
    end else begin
      ock_q <= {ock_q[1:0], ock_i};
      sdi_q <= {sdi_q[0], sdi_i};
    end
  end

  assign bit_en  = ock_q[1] & ~ock_q[2];
  assign sdi_bit = sdi_q[1];

  state_e          state_q;
  logic [1:0]      fill_q;
  logic [LOG2D-1:0] phase_q, phase_d;
  logic [AccW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [AccW-1:0] i3_prev_q, i3_prev_d, c1_prev_q, c1_prev_d, c2_prev_q, c2_prev_d;
  logic [AccW-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic            tick_q, tick_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic            clear;

  assign clear = !enable_i || (state_q == StIdle);

  always_comb begin
    phase_d   = phase_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    i3_prev_d = i3_prev_q;
    c1_prev_d = c1_prev_q;
    c2_prev_d = c2_prev_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    c3_d      = c3_q;
    tick_d    = 1'b0;
    v1_d      = tick_q;
    v2_d      = v1_q;
    v3_d      = v2_q;
    if (clear) begin
      phase_d   = '0;
      i1_d      = '0;
      i2_d      = '0;
      i3_d      = '0;
      i3_prev_d = '0;
      c1_prev_d = '0;
      c2_prev_d = '0;
      c1_d      = '0;
      c2_d      = '0;
      c3_d      = '0;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      v3_d      = 1'b0;
    end else begin
      if (bit_en) begin
        i1_d    = i1_q + {{(AccW-1){1'b0}}, sdi_bit};
        i2_d    = i2_q + i1_q;
        i3_d    = i3_q + i2_q;
        phase_d = phase_q + 1'b1;
        tick_d  = (phase_q == '1);
      end
      if (tick_q) begin
        c1_d      = i3_q - i3_prev_q;
        i3_prev_d = i3_q;
      end
      if (v1_q) begin
        c2_d      = c1_q - c1_prev_q;
        c1_prev_d = c1_q;
      end
      if (v2_q) begin
        c3_d      = c2_q - c2_prev_q;
        c2_prev_d = c2_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      i3_prev_q <= '0;
      c1_prev_q <= '0;
      c2_prev_q <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      c3_q      <= '0;
      tick_q    <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      i3_prev_q <= i3_prev_d;
      c1_prev_q <= c1_prev_d;
      c2_prev_q <= c2_prev_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      c3_q      <= c3_d;
      tick_q    <= tick_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
    end
  end

  // Only full scale (R**3) sets the top comb bit; it saturates instead of overflowing 32 bits.
  logic [31:0] mag, u, dout_d;
  always_comb begin
    mag    = 32'(c3_q[AccW-2:0]) << Shift;
    u      = c3_q[AccW-1] ? 32'hFFFF_FFFF : mag;
    dout_d = signed_data_i ? {~u[31], u[30:0]} : u;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      fill_q       <= '0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
    end else begin
      dout_valid_o <= 1'b0;
      if (!enable_i) begin
        state_q <= StIdle;
        fill_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StFill;
            fill_q  <= '0;
          end
          StFill: begin
            if (v3_q) begin
              if (fill_q == 2'd2) state_q <= StRun;
              else                fill_q  <= fill_q + 2'd1;
            end
          end
          StRun: begin
            if (v3_q) begin
              dout_o       <= dout_d;
              dout_valid_o <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
